cfs_irq_regs: RTL

Parametrised APB register block for the Aligner family. It generalises the fixed five-source register file: NUM_IRQ interrupt sources, per-source edge polarity, sticky write-1-to-clear status, a level interrupt output, and configurable APB wait states driven by an explicit access state machine. It sits between the APB slave port and the Aligner core, and drives CTRL fields into the datapath.

---
 rtl/cfs_irq_regs_pkg.sv | 17 +
 rtl/cfs_irq_edge.sv | 22 ++
 rtl/cfs_irq_regs.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cfs_irq_regs_pkg.sv
// cfs_irq_regs_pkg: register map, field positions, access FSM states and CTRL legality check.
package cfs_irq_regs_pkg;
  localparam int ADDR_CTRL    = 'h00;
  localparam int ADDR_STATUS  = 'h0C;
  localparam int ADDR_IRQEN   = 'hF0;
  localparam int ADDR_IRQ     = 'hF4;
  localparam int ADDR_IRQ_POL = 'hF8;
  localparam int ADDR_IRQ_SET = 'hFC;
  localparam int CTRL_OFFSET_LSB = 8;
  localparam int CTRL_CLR_BIT    = 16;
  localparam int STATUS_RX_LSB   = 8;
  localparam int STATUS_TX_LSB   = 16;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  function automatic logic ctrl_ok(input int size, input int offset, input int data_bytes);
    return size != 0 && (data_bytes + offset) % size == 0;
  endfunction
endpackage

// File: rtl/cfs_irq_edge.sv
// cfs_irq_edge: per-source polarity-selectable edge detector, silent until one cycle after reset release.
module cfs_irq_edge #(
  parameter int N = 5
) (
  input  logic         pclk,
  input  logic         presetn,
  input  logic [N-1:0] src,
  input  logic [N-1:0] pol,
  output logic [N-1:0] evt
);
  logic [N-1:0] prev;
  logic         armed;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= src;
      armed <= 1'b1;
    end
  assign evt = armed ? ((pol & prev & ~src) | (~pol & ~prev & src)) : '0;
endmodule

// File: rtl/cfs_irq_regs.sv
// cfs_irq_regs: APB register block with CTRL/STATUS and NUM_IRQ sticky edge interrupts.
// Define CFS_IRQ_REGS_SET_EN to map the write-only IRQ_SET test register at 0xFC.
module cfs_irq_regs
  import cfs_irq_regs_pkg::*;
#(
  parameter int APB_ADDR_WIDTH        = 16,
  parameter int ALGN_DATA_WIDTH       = 32,
  parameter int NUM_IRQ               = 5,
  parameter int WAIT_STATES           = 0,
  parameter int STATUS_CNT_DROP_WIDTH = 8,
  parameter int STATUS_RX_LVL_WIDTH   = 4,
  parameter int STATUS_TX_LVL_WIDTH   = 4,
  localparam int DATA_BYTES = ALGN_DATA_WIDTH / 8,
  localparam int SIZE_W     = $clog2(DATA_BYTES) + 1,
  localparam int OFFSET_W   = ($clog2(DATA_BYTES) < 1) ? 1 : $clog2(DATA_BYTES)
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic [APB_ADDR_WIDTH-1:0]        paddr,
  input  logic                             psel,
  input  logic                             penable,
  input  logic                             pwrite,
  input  logic [31:0]                      pwdata,
  output logic                             pready,
  output logic                             pslverr,
  output logic [31:0]                      prdata,
  output logic [SIZE_W-1:0]                ctrl_size,
  output logic [OFFSET_W-1:0]              ctrl_offset,
  output logic                             ctrl_clr,
  input  logic [STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
  input  logic [STATUS_RX_LVL_WIDTH-1:0]   status_rx_lvl,
  input  logic [STATUS_TX_LVL_WIDTH-1:0]   status_tx_lvl,
  input  logic [NUM_IRQ-1:0]               irq_src,
  output logic                             irq
);
  state_t                    state;
  logic [3:0]                cnt;
  logic [NUM_IRQ-1:0]        irq_en, irq_r, irq_pol, evt, w1c, set_v;
  logic [APB_ADDR_WIDTH-1:0] a;
  logic                      hit_ctrl, hit_status, hit_irqen, hit_irq, hit_pol, hit_set;
  logic                      err, commit, wr;
  logic [31:0]               rdata;
  logic                      unused;
  assign unused     = ^{paddr[1:0], pwdata};
  assign a          = {paddr[APB_ADDR_WIDTH-1:2], 2'b00};
  assign hit_ctrl   = a == APB_ADDR_WIDTH'(ADDR_CTRL);
  assign hit_status = a == APB_ADDR_WIDTH'(ADDR_STATUS);
  assign hit_irqen  = a == APB_ADDR_WIDTH'(ADDR_IRQEN);
  assign hit_irq    = a == APB_ADDR_WIDTH'(ADDR_IRQ);
  assign hit_pol    = a == APB_ADDR_WIDTH'(ADDR_IRQ_POL);
`ifdef CFS_IRQ_REGS_SET_EN
  assign hit_set    = a == APB_ADDR_WIDTH'(ADDR_IRQ_SET);
`else
  assign hit_set    = 1'b0;
`endif
  assign err = !(hit_ctrl | hit_status | hit_irqen | hit_irq | hit_pol | hit_set)
             || (pwrite && hit_status)
             || (pwrite && hit_ctrl && !ctrl_ok(int'(pwdata[SIZE_W-1:0]),
                                                int'(pwdata[CTRL_OFFSET_LSB +: OFFSET_W]), DATA_BYTES));
  // The commit edge is the one that moves WAIT into RESP.
  assign commit = state == S_WAIT && psel && cnt <= 4'd1;
  assign wr     = commit && pwrite && !err;
  assign w1c    = (wr && hit_irq) ? pwdata[NUM_IRQ-1:0] : '0;
  assign set_v  = (wr && hit_set) ? pwdata[NUM_IRQ-1:0] : '0;
  assign rdata  = hit_ctrl   ? (32'(ctrl_size) | (32'(ctrl_offset) << CTRL_OFFSET_LSB))
                : hit_status ? (32'(status_cnt_drop) | (32'(status_rx_lvl) << STATUS_RX_LSB)
                                | (32'(status_tx_lvl) << STATUS_TX_LSB))
                : hit_irqen  ? 32'(irq_en)
                : hit_irq    ? 32'(irq_r)
                : hit_pol    ? 32'(irq_pol)
                : '0;
  cfs_irq_edge #(.N(NUM_IRQ)) u_edge (
    .pclk    (pclk),
    .presetn (presetn),
    .src     (irq_src),
    .pol     (irq_pol),
    .evt     (evt)
  );
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      prdata      <= '0;
      ctrl_size   <= SIZE_W'(1);
      ctrl_offset <= '0;
      ctrl_clr    <= 1'b0;
    end else begin
      ctrl_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          if (psel && penable) begin
            state <= S_WAIT;
            cnt   <= 4'(WAIT_STATES);
          end
        end
        S_WAIT:
          if (!psel) state <= S_IDLE;
          else if (commit) begin
            state   <= S_RESP;
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= (err || pwrite) ? '0 : rdata;
            if (wr && hit_ctrl) begin
              ctrl_size   <= pwdata[SIZE_W-1:0];
              ctrl_offset <= pwdata[CTRL_OFFSET_LSB +: OFFSET_W];
              ctrl_clr    <= pwdata[CTRL_CLR_BIT];
            end
          end else cnt <= cnt - 4'd1;
        default: begin
          state   <= S_IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
      endcase
    end
  // A source event in the same cycle as a W1C leaves the bit set.
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      irq_en  <= '1;
      irq_r   <= '0;
      irq_pol <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr && hit_irqen) irq_en <= pwdata[NUM_IRQ-1:0];
      if (wr && hit_pol) irq_pol <= pwdata[NUM_IRQ-1:0];
      irq_r <= (irq_r & ~w1c) | set_v | evt;
      irq   <= |(irq_r & irq_en);
    end
endmodule
